// File: rtl/servo_pwm_multi_if.sv
// rtl/servo_pwm_multi_if.sv - duty write port bundle for servo_pwm_multi
interface servo_pwm_multi_if #(
  parameter int CH_W   = 2,
  parameter int DUTY_W = 11
);
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DUTY_W-1:0] wr_duty;
  logic              wr_ack;

  modport master (output wr_en, output wr_ch, output wr_duty, input wr_ack);
  modport slave  (input wr_en, input wr_ch, input wr_duty, output wr_ack);
endinterface

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with per-frame duty update and slew limit
module servo_pwm_multi #(
  parameter int CHANNELS  = 4,
  parameter int PRESC     = 500,
  parameter int PERIOD    = 2000,
  parameter int DUTY_W    = 11,
  parameter int SLEW_STEP = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  servo_pwm_multi_if.slave    wr,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = $clog2(PRESC);
  localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESC - 1);
  localparam logic [DUTY_W-1:0] PER_MAX   = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] PER_FULL  = DUTY_W'(PERIOD);
  localparam logic [DUTY_W:0]   SLEW      = (DUTY_W + 1)'(SLEW_STEP);
  localparam logic [CH_W:0]     CH_LIM    = (CH_W + 1)'(CHANNELS);

  logic [PW-1:0]     presc;
  logic [DUTY_W-1:0] fcnt;
  logic              tick;
  logic              wrap_d;
  logic              en_d;
  logic              boundary;
  logic              wr_ok;
  logic [DUTY_W-1:0] wr_clamped;
  logic [DUTY_W-1:0] target      [CHANNELS];
  logic [DUTY_W-1:0] active      [CHANNELS];
  logic [DUTY_W-1:0] next_active [CHANNELS];
  logic [CHANNELS-1:0] cmp;
  logic [DUTY_W:0]   ta;
  logic [DUTY_W:0]   ac;
  logic [DUTY_W:0]   diff;
  logic [DUTY_W:0]   step;
  logic [DUTY_W:0]   na;

  assign tick = en && (presc == PRESC_MAX);
  // A boundary is the first cycle of a frame: counter just wrapped, or generator just started.
  assign boundary = en && (!en_d || wrap_d);

  // Prescaler and frame counter; both pinned to zero while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      presc <= '0;
      fcnt  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) fcnt <= (fcnt == PER_MAX) ? '0 : fcnt + 1'b1;
    end
  end

  // Remember previous enable and the wrap so the boundary lands on the count-0 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_d   <= 1'b0;
      wrap_d <= 1'b0;
    end else begin
      en_d   <= en;
      wrap_d <= tick && (fcnt == PER_MAX);
    end
  end

  assign wr_ok      = wr.wr_en && ({1'b0, wr.wr_ch} < CH_LIM);
  assign wr_clamped = (wr.wr_duty > PER_FULL) ? PER_FULL : wr.wr_duty;

  // Host writes land in target immediately; out-of-range channels are dropped silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr.wr_ack <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) target[i] <= '0;
    end else begin
      wr.wr_ack <= wr_ok;
      if (wr_ok) target[wr.wr_ch] <= wr_clamped;
    end
  end

  // Duty the channel adopts at the next boundary, limited to SLEW ticks of movement.
  always_comb begin
    ta   = '0;
    ac   = '0;
    diff = '0;
    step = '0;
    na   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ta   = {1'b0, target[i]};
      ac   = {1'b0, active[i]};
      diff = (ta > ac) ? (ta - ac) : (ac - ta);
      step = (diff > SLEW) ? SLEW : diff;
      if (SLEW_STEP == 0) na = ta;
      else if (ta > ac)   na = ac + step;
      else                na = ac - step;
      next_active[i] = na[DUTY_W-1:0];
    end
  end

  // Active duty only changes on a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
    end else if (boundary) begin
      for (int i = 0; i < CHANNELS; i++) active[i] <= next_active[i];
    end
  end

  // The boundary cycle already compares against the incoming duty, so frames start clean.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++)
      cmp[i] = fcnt < (boundary ? next_active[i] : active[i]);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      pwm_out     <= en ? cmp : '0;
      frame_start <= boundary;
    end
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - directed self-checking bench for servo_pwm_multi
module tb_servo_pwm_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] pwm0;
  logic [2:0] pwm1;
  logic [1:0] pwm2;
  logic       fs0, fs1, fs2;
  int         n_checks = 0;
  int         n_errors = 0;
  int         hi0, hi1, hi2, fsc, waited;
  int         cnt;
  int         slew_up [5] = '{8, 16, 24, 28, 28};
  int         slew_dn [4] = '{20, 12, 4, 0};

  servo_pwm_multi_if #(.CH_W(1), .DUTY_W(4)) if0 ();
  servo_pwm_multi_if #(.CH_W(2), .DUTY_W(4)) if1 ();
  servo_pwm_multi_if #(.CH_W(1), .DUTY_W(4)) if2 ();

  servo_pwm_multi #(.CHANNELS(2), .PRESC(4), .PERIOD(10), .DUTY_W(4), .SLEW_STEP(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .wr(if0), .pwm_out(pwm0), .frame_start(fs0));
  servo_pwm_multi #(.CHANNELS(3), .PRESC(4), .PERIOD(10), .DUTY_W(4), .SLEW_STEP(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .wr(if1), .pwm_out(pwm1), .frame_start(fs1));
  servo_pwm_multi #(.CHANNELS(2), .PRESC(4), .PERIOD(10), .DUTY_W(4), .SLEW_STEP(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .wr(if2), .pwm_out(pwm2), .frame_start(fs2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int dut, output logic [2:0] p, output logic f);
    case (dut)
      0:       begin p = {1'b0, pwm0}; f = fs0; end
      1:       begin p = pwm1;         f = fs1; end
      default: begin p = {1'b0, pwm2}; f = fs2; end
    endcase
  endtask

  // Wait for frame_start (bounded), then count high cycles per bit over one 40-cycle frame.
  task automatic measure(input int dut, output int h0, output int h1, output int h2,
                         output int fcount, output int nwait);
    logic [2:0] p;
    logic       f;
    nwait = 0;
    sample(dut, p, f);
    while (!f && nwait < 200) begin
      @(negedge clk);
      nwait++;
      sample(dut, p, f);
    end
    check("frame_start_seen", int'(f), 1);
    h0 = 0; h1 = 0; h2 = 0; fcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      sample(dut, p, f);
      h0 += int'(p[0]);
      h1 += int'(p[1]);
      h2 += int'(p[2]);
      fcount += int'(f);
    end
  endtask

  task automatic clear_writes();
    if0.wr_en = 1'b0; if0.wr_ch = '0; if0.wr_duty = '0;
    if1.wr_en = 1'b0; if1.wr_ch = '0; if1.wr_duty = '0;
    if2.wr_en = 1'b0; if2.wr_ch = '0; if2.wr_duty = '0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clear_writes();
    repeat (2) @(negedge clk);
    check("rst_pwm", int'(pwm0), 0);
    check("rst_frame_start", int'(fs0), 0);
    check("rst_ack", int'(if0.wr_ack), 0);

    // Write during reset must be discarded.
    if0.wr_en = 1'b1; if0.wr_ch = 1'b0; if0.wr_duty = 4'd3;
    @(negedge clk);
    check("rst_write_ack", int'(if0.wr_ack), 0);
    clear_writes();
    rst = 1'b0;
    @(negedge clk);

    // Writes while disabled; clamp and invalid channel on the 3-channel instance.
    if0.wr_en = 1'b1; if0.wr_ch = 1'b0; if0.wr_duty = 4'd3;
    if1.wr_en = 1'b1; if1.wr_ch = 2'd0; if1.wr_duty = 4'd15;
    @(negedge clk);
    check("ack_ch0", int'(if0.wr_ack), 1);
    check("clamp_ack", int'(if1.wr_ack), 1);
    if0.wr_ch = 1'b1; if0.wr_duty = 4'd10;
    if1.wr_ch = 2'd3; if1.wr_duty = 4'd0;
    @(negedge clk);
    check("ack_b2b", int'(if0.wr_ack), 1);
    check("invalid_ack", int'(if1.wr_ack), 0);
    clear_writes();
    @(negedge clk);
    check("ack_single_pulse", int'(if0.wr_ack), 0);
    check("disabled_pwm", int'(pwm0), 0);

    en = 1'b1;
    measure(1, hi0, hi1, hi2, fsc, waited);
    check("clamp_ch0_high", hi0, 40);
    check("invalid_ch1_high", hi1, 0);
    check("invalid_ch2_high", hi2, 0);

    measure(0, hi0, hi1, hi2, fsc, waited);
    check("basic_ch0_high", hi0, 12);
    check("basic_ch1_high", hi1, 40);
    check("basic_fs_count", fsc, 1);
    measure(0, hi0, hi1, hi2, fsc, waited);
    check("basic2_ch0_high", hi0, 12);
    check("basic2_ch1_high", hi1, 40);
    check("fs_period_gap", waited, 1);

    // Write presented in the boundary cycle.
    if0.wr_en = 1'b1; if0.wr_ch = 1'b0; if0.wr_duty = 4'd5;
    @(negedge clk);
    check("collide_ack", int'(if0.wr_ack), 1);
    check("collide_on_boundary", int'(fs0), 1);
    clear_writes();
    measure(0, hi0, hi1, hi2, fsc, waited);
    check("collide_old_duty", hi0, 12);
    measure(0, hi0, hi1, hi2, fsc, waited);
    check("collide_new_duty", hi0, 20);

    // Drop enable mid-frame while ch0 is high.
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("en_drop_pre_high", int'(pwm0[0]), 1);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_pwm", int'(pwm0), 0);
    cnt = int'(fs0);
    repeat (50) begin
      @(negedge clk);
      cnt += int'(fs0);
    end
    check("en_low_no_fs", cnt, 0);
    en = 1'b1;
    measure(0, hi0, hi1, hi2, fsc, waited);
    check("reen_fs_latency", waited, 1);
    check("reen_ch0_high", hi0, 20);
    check("reen_ch1_high", hi1, 40);

    // Slew limiting, ramp up then down.
    @(negedge clk);
    if2.wr_en = 1'b1; if2.wr_ch = 1'b0; if2.wr_duty = 4'd7;
    @(negedge clk);
    check("slew_ack", int'(if2.wr_ack), 1);
    clear_writes();
    for (int k = 0; k < 5; k++) begin
      measure(2, hi0, hi1, hi2, fsc, waited);
      check($sformatf("slew_up_%0d", k), hi0, slew_up[k]);
    end
    @(negedge clk);
    if2.wr_en = 1'b1; if2.wr_ch = 1'b0; if2.wr_duty = 4'd0;
    @(negedge clk);
    clear_writes();
    for (int k = 0; k < 4; k++) begin
      measure(2, hi0, hi1, hi2, fsc, waited);
      check($sformatf("slew_dn_%0d", k), hi0, slew_dn[k]);
    end

    // Reset mid-frame with nonzero duties.
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_mid_pre_high", int'(pwm0[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm0", int'(pwm0), 0);
    check("rst_mid_pwm1", int'(pwm1), 0);
    check("rst_mid_fs", int'(fs0), 0);
    rst = 1'b0;
    measure(0, hi0, hi1, hi2, fsc, waited);
    check("post_rst_fs_latency", waited, 1);
    check("post_rst_ch0_high", hi0, 0);
    check("post_rst_ch1_high", hi1, 0);
    measure(1, hi0, hi1, hi2, fsc, waited);
    check("post_rst_u1_ch0_high", hi0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
